// File: rtl/modulo_counter.sv
`default_nettype none
// ============================================================================
// Module   : modulo_counter
// Brief    : Up/down modulo counter with programmable terminal value,
//            synchronous load, prescaled enable, wrap/saturate selection and
//            a registered one-cycle event pulse at the bounds.
// Revision : 1.0 - initial release
// ============================================================================
module modulo_counter #(
  parameter int WIDTH          = 4,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      up_i,
  input  logic                      saturate_i,
  input  logic                      load_i,
  input  logic [WIDTH-1:0]          load_value_i,
  input  logic [WIDTH-1:0]          limit_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [WIDTH-1:0]          count_o,
  output logic                      pulse_o,
  output logic                      zero_o,
  output logic                      at_limit_o
);

  localparam logic [WIDTH-1:0]          ZERO_COUNT = '0;
  localparam logic [WIDTH-1:0]          ONE_COUNT  = WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] ZERO_PSC   = '0;
  localparam logic [PRESCALE_WIDTH-1:0] ONE_PSC    = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] psc;
  logic                      tick;
  logic [WIDTH-1:0]          load_clamped;
  logic [WIDTH-1:0]          count_next;
  logic                      pulse_next;

  // A tick fires on the enabled cycle where the prescaler reaches its terminal.
  assign tick         = enable_i && (psc == prescale_i);
  // Loads above the terminal value are pulled back into range.
  assign load_clamped = (load_value_i > limit_i) ? limit_i : load_value_i;

  assign zero_o     = (count_o == ZERO_COUNT);
  assign at_limit_o = (count_o == limit_i);

  // Next count and boundary event for a tick in the current direction/mode.
  always_comb begin
    count_next = count_o;
    pulse_next = 1'b0;
    if (up_i) begin
      if (count_o < limit_i) begin
        count_next = count_o + ONE_COUNT;
      end else begin
        // At or beyond the limit (limit may have been lowered): bound event.
        count_next = saturate_i ? limit_i : ZERO_COUNT;
        pulse_next = 1'b1;
      end
    end else begin
      if (count_o > limit_i) begin
        // Out of range after a limit decrease: snap silently to the limit.
        count_next = limit_i;
      end else if (count_o == ZERO_COUNT) begin
        count_next = saturate_i ? ZERO_COUNT : limit_i;
        pulse_next = 1'b1;
      end else begin
        count_next = count_o - ONE_COUNT;
      end
    end
  end

  // Count, pulse and prescaler state; priority reset > load > tick > hold.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_o <= ZERO_COUNT;
      pulse_o <= 1'b0;
      psc     <= ZERO_PSC;
    end else if (load_i) begin
      // A tick coincident with a load is discarded.
      count_o <= load_clamped;
      pulse_o <= 1'b0;
      psc     <= ZERO_PSC;
    end else begin
      pulse_o <= 1'b0;
      if (enable_i) begin
        // Clearing also covers psc stranded above a newly lowered prescale.
        if (tick || (psc > prescale_i)) begin
          psc <= ZERO_PSC;
        end else begin
          psc <= psc + ONE_PSC;
        end
      end
      if (tick) begin
        count_o <= count_next;
        pulse_o <= pulse_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_modulo_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulo_counter
// Brief    : Directed self-checking bench for modulo_counter (WIDTH=4,
//            PRESCALE_WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic       saturate = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] limit = '0;
  logic [3:0] prescale = '0;
  logic [3:0] count;
  logic       pulse;
  logic       zero;
  logic       at_limit;

  int pass_cnt = 0;
  int total_cnt = 0;

  modulo_counter #(.WIDTH(4), .PRESCALE_WIDTH(4)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .enable_i     (enable),
    .up_i         (up),
    .saturate_i   (saturate),
    .load_i       (load),
    .load_value_i (load_value),
    .limit_i      (limit),
    .prescale_i   (prescale),
    .count_o      (count),
    .pulse_o      (pulse),
    .zero_o       (zero),
    .at_limit_o   (at_limit)
  );

  // 10 ns clock period.
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Synchronous load of value v (one edge).
  task automatic do_load(input logic [3:0] v);
    load_value = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1; up = 1'b1; saturate = 1'b0; load = 1'b0;
    limit = 4'd15; prescale = 4'd0; reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if (count !== 4'd0 || pulse !== 1'b0 || zero !== 1'b1) begin
      $display("FAIL reset_state: count=%0d pulse=%b zero=%b, need 0/0/1", count, pulse, zero);
    end else pass_cnt++;
    for (int i = 1; i <= 17; i++) begin
      logic [3:0] ec;
      logic       ep;
      step();
      ec = 4'(i % 16);
      ep = (i == 16);
      total_cnt++;
      if (count !== ec || pulse !== ep || at_limit !== (ec == 4'd15)) begin
        $display("FAIL free_run[%0d]: count=%0d pulse=%b at_limit=%b, need %0d/%b/%b",
                 i, count, pulse, at_limit, ec, ep, (ec == 4'd15));
      end else pass_cnt++;
    end
  endtask

  task automatic test_prescale();
    limit = 4'd9; prescale = 4'd2; up = 1'b1; saturate = 1'b0; enable = 1'b1;
    do_load(4'd0);
    // After n enabled edges from psc=0: count=(n/3)%10, pulse when n%30==0.
    for (int n = 1; n <= 34; n++) begin
      logic [3:0] ec;
      logic       ep;
      step();
      ec = 4'((n / 3) % 10);
      ep = (n % 30 == 0);
      total_cnt++;
      if (count !== ec || pulse !== ep) begin
        $display("FAIL prescale[%0d]: count=%0d pulse=%b, need %0d/%b", n, count, pulse, ec, ep);
      end else pass_cnt++;
    end
    // Now count=1, psc=1. Freeze for 5 edges.
    enable = 1'b0;
    for (int n = 0; n < 5; n++) step();
    total_cnt++;
    if (count !== 4'd1 || pulse !== 1'b0) begin
      $display("FAIL enable_freeze: count=%0d pulse=%b, need 1/0", count, pulse);
    end else pass_cnt++;
    enable = 1'b1;
    step();
    total_cnt++;
    if (count !== 4'd1) begin
      $display("FAIL phase_kept_a: count=%0d, need 1", count);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (count !== 4'd2) begin
      $display("FAIL phase_kept_b: count=%0d, need 2", count);
    end else pass_cnt++;
  endtask

  task automatic test_down();
    logic [3:0] wrap_c [4] = '{4'd1, 4'd0, 4'd5, 4'd4};
    logic       wrap_p [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] sat_c  [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic       sat_p  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    limit = 4'd5; prescale = 4'd0; up = 1'b0; saturate = 1'b0; enable = 1'b1;
    do_load(4'd2);
    total_cnt++;
    if (count !== 4'd2 || pulse !== 1'b0) begin
      $display("FAIL down_load: count=%0d pulse=%b, need 2/0", count, pulse);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (count !== wrap_c[i] || pulse !== wrap_p[i]) begin
        $display("FAIL down_wrap[%0d]: count=%0d pulse=%b, need %0d/%b",
                 i, count, pulse, wrap_c[i], wrap_p[i]);
      end else pass_cnt++;
    end
    saturate = 1'b1;
    do_load(4'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (count !== sat_c[i] || pulse !== sat_p[i]) begin
        $display("FAIL down_sat[%0d]: count=%0d pulse=%b, need %0d/%b",
                 i, count, pulse, sat_c[i], sat_p[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_load();
    limit = 4'd7; up = 1'b1; saturate = 1'b0; prescale = 4'd0; enable = 1'b1;
    do_load(4'd12);
    total_cnt++;
    if (count !== 4'd7 || pulse !== 1'b0 || at_limit !== 1'b1) begin
      $display("FAIL load_clamp: count=%0d pulse=%b at_limit=%b, need 7/0/1", count, pulse, at_limit);
    end else pass_cnt++;
    // count==limit and a tick is due this edge; the load must win.
    do_load(4'd3);
    total_cnt++;
    if (count !== 4'd3 || pulse !== 1'b0) begin
      $display("FAIL load_over_tick: count=%0d pulse=%b, need 3/0", count, pulse);
    end else pass_cnt++;
  endtask

  task automatic test_limit_change();
    enable = 1'b1; prescale = 4'd0; saturate = 1'b0;
    limit = 4'd15;
    do_load(4'd8);
    limit = 4'd3; up = 1'b1;
    step();
    total_cnt++;
    if (count !== 4'd0 || pulse !== 1'b1) begin
      $display("FAIL limit_drop_up: count=%0d pulse=%b, need 0/1", count, pulse);
    end else pass_cnt++;
    limit = 4'd15;
    do_load(4'd8);
    limit = 4'd3; up = 1'b0;
    step();
    total_cnt++;
    if (count !== 4'd3 || pulse !== 1'b0) begin
      $display("FAIL limit_drop_down: count=%0d pulse=%b, need 3/0", count, pulse);
    end else pass_cnt++;
    limit = 4'd0;
    do_load(4'd9);
    total_cnt++;
    if (count !== 4'd0) begin
      $display("FAIL limit0_load: count=%0d, need 0", count);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      up = i[0];
      saturate = i[1];
      step();
      total_cnt++;
      if (count !== 4'd0 || pulse !== 1'b1 || zero !== 1'b1 || at_limit !== 1'b1) begin
        $display("FAIL limit0_tick[%0d]: count=%0d pulse=%b zero=%b at_limit=%b, need 0/1/1/1",
                 i, count, pulse, zero, at_limit);
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    limit = 4'd15; prescale = 4'd2; up = 1'b1; saturate = 1'b0; enable = 1'b1;
    do_load(4'd5);             // count 5, psc 0
    step();                    // psc 1
    // Reset pulse entirely between edges must be ignored.
    reset = 1'b1; #3; reset = 1'b0;
    total_cnt++;
    if (count !== 4'd5) begin
      $display("FAIL reset_glitch_a: count=%0d, need 5", count);
    end else pass_cnt++;
    step();                    // psc 2
    step();                    // tick: count 6, psc 0
    step();                    // psc 1
    total_cnt++;
    if (count !== 4'd6) begin
      $display("FAIL reset_glitch_b: count=%0d, need 6", count);
    end else pass_cnt++;
    reset = 1'b1;
    #2;
    total_cnt++;
    if (count !== 4'd6) begin
      $display("FAIL reset_before_edge: count=%0d, need 6", count);
    end else pass_cnt++;
    step();
    reset = 1'b0;
    total_cnt++;
    if (count !== 4'd0 || pulse !== 1'b0) begin
      $display("FAIL reset_mid: count=%0d pulse=%b, need 0/0", count, pulse);
    end else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (count !== 4'd0) begin
      $display("FAIL reset_psc_cleared: count=%0d, need 0", count);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (count !== 4'd1) begin
      $display("FAIL reset_first_tick: count=%0d, need 1", count);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_down();
    test_load();
    test_limit_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
